// File: rtl/udp_cmd_client.sv
// udp_cmd_client: issues one command over a UDP tx/rx byte interface and waits for the reply.
// Define UDP_CMD_CLIENT_RETRY_EN to retransmit up to MAX_RETRY times on reply timeout.
module udp_cmd_client #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned PAYLOAD_LEN    = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_code,
    input  logic [7:0] cmd_arg,
    output logic       rsp_valid,
    output logic [7:0] rsp_code,
    output logic [7:0] rsp_arg,
    output logic       rsp_timeout,
    output logic       evt_valid,
    output logic       tx_start,
    output logic [9:0] tx_len,
    input  logic [9:0] tx_data_pos,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       rx_data_avail,
    input  logic [7:0] rx_data,
    input  logic [9:0] rx_data_pos,
    input  logic       rx_is_udp,
    input  logic       rx_stop,
    input  logic       rx_crc_valid
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`ifdef UDP_CMD_CLIENT_RETRY_EN
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RETRY_W-1:0] retry;
`endif

    typedef enum logic [1:0] {IDLE, SEND, WAIT_TX, WAIT_RSP} state_t;

    state_t           state;
    logic [7:0]       code_q;
    logic [7:0]       arg_q;
    logic [7:0]       sh_code;
    logic [7:0]       sh_arg;
    logic [CNT_W-1:0] tmo;
    logic             seen_busy;
    logic             accept;

    assign tx_len = 10'(PAYLOAD_LEN);
    assign accept = rx_stop && rx_crc_valid && rx_is_udp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            tx_start    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            evt_valid   <= 1'b0;
            rsp_code    <= 8'h00;
            rsp_arg     <= 8'h00;
            tx_data     <= 8'h00;
            code_q      <= 8'h00;
            arg_q       <= 8'h00;
            sh_code     <= 8'h00;
            sh_arg      <= 8'h00;
            tmo         <= '0;
            seen_busy   <= 1'b0;
`ifdef UDP_CMD_CLIENT_RETRY_EN
            retry       <= '0;
`endif
        end else begin
            tx_start    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            evt_valid   <= 1'b0;

            // payload served one cycle after the transmitter asks for a position
            case (tx_data_pos)
                10'd0:   tx_data <= code_q;
                10'd1:   tx_data <= arg_q;
                default: tx_data <= 8'h00;
            endcase

            if (rx_data_avail && rx_is_udp) begin
                if (rx_data_pos == 10'd0) sh_code <= rx_data;
                if (rx_data_pos == 10'd1) sh_arg  <= rx_data;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        rsp_code  <= sh_code;
                        rsp_arg   <= sh_arg;
                        evt_valid <= 1'b1;
                    end
                    if (cmd_valid) begin
                        code_q    <= cmd_code;
                        arg_q     <= cmd_arg;
                        cmd_ready <= 1'b0;
                        state     <= SEND;
`ifdef UDP_CMD_CLIENT_RETRY_EN
                        retry     <= '0;
`endif
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_start  <= 1'b1;
                        seen_busy <= 1'b0;
                        state     <= WAIT_TX;
                    end
                end
                WAIT_TX: begin
                    // the transmitter must go busy and then idle again before the reply window opens
                    if (!seen_busy) begin
                        if (tx_busy) seen_busy <= 1'b1;
                    end else if (!tx_busy) begin
                        tmo   <= CNT_W'(TIMEOUT_CYCLES - 1);
                        state <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (accept) begin
                        rsp_code  <= sh_code;
                        rsp_arg   <= sh_arg;
                        rsp_valid <= 1'b1;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (tmo == '0) begin
`ifdef UDP_CMD_CLIENT_RETRY_EN
                        if (retry < RETRY_W'(MAX_RETRY)) begin
                            retry <= retry + RETRY_W'(1);
                            state <= SEND;
                        end else begin
                            rsp_timeout <= 1'b1;
                            cmd_ready   <= 1'b1;
                            state       <= IDLE;
                        end
`else
                        rsp_timeout <= 1'b1;
                        cmd_ready   <= 1'b1;
                        state       <= IDLE;
`endif
                    end else begin
                        tmo <= tmo - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_udp_cmd_client.sv
// tb_udp_cmd_client: directed scenarios for udp_cmd_client with a transaction-level reference model.
// Expected attempt count follows UDP_CMD_CLIENT_RETRY_EN.
module tb_udp_cmd_client;
    localparam int unsigned TO = 50;
    localparam int unsigned MR = 3;
    localparam int unsigned PL = 18;
`ifdef UDP_CMD_CLIENT_RETRY_EN
    localparam int ATTEMPTS = MR + 1;
`else
    localparam int ATTEMPTS = 1;
`endif
    localparam int K_NONE  = 0;
    localparam int K_VALID = 1;
    localparam int K_EVT   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_code = 8'h00;
    logic [7:0] cmd_arg = 8'h00;
    logic       cmd_ready, rsp_valid, rsp_timeout, evt_valid, tx_start;
    logic [7:0] rsp_code, rsp_arg, tx_data;
    logic [9:0] tx_len;
    logic [9:0] tx_data_pos = 10'd2;
    logic       tx_hold = 1'b0;
    logic       busy_auto = 1'b0;
    logic       tx_busy;
    logic       rx_data_avail = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [9:0] rx_data_pos = 10'd0;
    logic       rx_is_udp = 1'b0;
    logic       rx_stop = 1'b0;
    logic       rx_crc_valid = 1'b0;

    assign tx_busy = tx_hold | busy_auto;

    udp_cmd_client #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR), .PAYLOAD_LEN(PL)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code), .cmd_arg(cmd_arg),
        .rsp_valid(rsp_valid), .rsp_code(rsp_code), .rsp_arg(rsp_arg),
        .rsp_timeout(rsp_timeout), .evt_valid(evt_valid),
        .tx_start(tx_start), .tx_len(tx_len), .tx_data_pos(tx_data_pos), .tx_data(tx_data),
        .tx_busy(tx_busy),
        .rx_data_avail(rx_data_avail), .rx_data(rx_data), .rx_data_pos(rx_data_pos),
        .rx_is_udp(rx_is_udp), .rx_stop(rx_stop), .rx_crc_valid(rx_crc_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // scenario-owned expectations
    int         exp_kind = K_NONE;
    logic [7:0] exp_code = 8'h00;
    logic [7:0] exp_arg = 8'h00;
    int         good_stop_cyc = -10;

    // model / observation state
    logic       s_rst = 1'b1, s_cmd_valid = 1'b0, s_busy = 1'b0;
    logic [7:0] s_code = 8'h00, s_arg = 8'h00;
    logic [9:0] s_pos = 10'd2;
    logic       pend = 1'b0;
    logic [7:0] m_code = 8'h00, m_arg = 8'h00;
    logic       prev_busy = 1'b0, prev_start = 1'b0;
    int         fall_cyc = 0;
    int         n_start = 0, n_valid = 0, n_to = 0, n_evt = 0, n_fall = 0;
    logic [7:0] cap [0:3] = '{default: 8'hAA};

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        s_rst       <= rst;
        s_cmd_valid <= cmd_valid;
        s_code      <= cmd_code;
        s_arg       <= cmd_arg;
        s_pos       <= tx_data_pos;
        s_busy      <= tx_busy;
    end

    always @(negedge clk) begin
        logic [7:0] exp_tx;
        if (cyc > 0) begin
            // payload byte follows the position asked for on the previous edge
            if (s_rst)             exp_tx = 8'h00;
            else if (s_pos == 0)   exp_tx = m_code;
            else if (s_pos == 1)   exp_tx = m_arg;
            else                   exp_tx = 8'h00;
            chk("tx_data", 32'(tx_data), 32'(exp_tx));
            if (s_busy && s_pos < 4) cap[s_pos[1:0]] = tx_data;

            if (rsp_valid || rsp_timeout) chk("done_without_cmd", 32'(pend), 32'd1);
            if (s_rst) begin
                pend = 1'b0;
                chk("rst_pulses", 32'({tx_start, rsp_valid, rsp_timeout, evt_valid}), 32'd0);
            end else if (s_cmd_valid && !pend) begin
                pend   = 1'b1;
                m_code = s_code;
                m_arg  = s_arg;
            end else if (rsp_valid || rsp_timeout) begin
                pend = 1'b0;
            end
            chk("cmd_ready", 32'(cmd_ready), 32'(!pend));
            chk("exclusive", 32'(rsp_valid) + 32'(rsp_timeout) + 32'(evt_valid) <= 1 ? 32'd1 : 32'd0, 32'd1);

            if (tx_start) begin
                n_start++;
                chk("tx_start_ok", 32'(pend && !s_busy && !prev_start), 32'd1);
            end
            if (cyc == good_stop_cyc + 1) begin
                chk("rsp_valid_kind", 32'(rsp_valid), 32'(exp_kind == K_VALID));
                chk("evt_valid_kind", 32'(evt_valid), 32'(exp_kind == K_EVT));
            end
            if (rsp_valid || evt_valid) begin
                chk("pulse_lat", 32'(cyc), 32'(good_stop_cyc + 1));
                chk("rsp_code", 32'(rsp_code), 32'(exp_code));
                chk("rsp_arg", 32'(rsp_arg), 32'(exp_arg));
            end
            if (rsp_valid) n_valid++;
            if (evt_valid) n_evt++;
            if (rsp_timeout) begin
                n_to++;
                // the DUT sees tx_busy low on the next edge, then waits TO cycles
                chk("timeout_lat", 32'(cyc), 32'(fall_cyc + int'(TO) + 1));
            end
            if (prev_busy && !tx_busy) begin
                n_fall++;
                fall_cyc = cyc;
            end
            prev_busy  = tx_busy;
            prev_start = tx_start;
        end
    end

    // external transmitter: busy for 40 cycles after each start, sweeping payload positions
    always begin
        @(negedge clk);
        if (tx_start) begin
            @(posedge clk); #1;
            busy_auto = 1'b1;
            for (int k = 0; k < 40; k++) begin
                tx_data_pos = 10'(k);
                @(posedge clk); #1;
            end
            busy_auto   = 1'b0;
            tx_data_pos = 10'd2;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic issue_cmd(input logic [7:0] c, input logic [7:0] a);
        cmd_code = c; cmd_arg = a; cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] c, input logic [7:0] a, input logic crc, input logic udp);
        rx_is_udp = udp;
        for (int p = 0; p < 3; p++) begin
            rx_data_avail = 1'b1;
            rx_data_pos   = 10'(p);
            rx_data       = (p == 0) ? c : (p == 1) ? a : 8'h5E;
            tick(1);
        end
        rx_data_avail = 1'b0;
        rx_stop       = 1'b1;
        rx_crc_valid  = crc;
        if (crc && udp) good_stop_cyc = cyc;
        tick(1);
        rx_stop = 1'b0; rx_crc_valid = 1'b0; rx_is_udp = 1'b0;
    endtask

    task automatic wait_fall(input int budget);
        int base = n_fall;
        int k = 0;
        while (n_fall == base && k < budget) begin tick(1); k++; end
        chk("wait_fall_bound", 32'(n_fall != base), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (!cmd_ready && k < budget) begin tick(1); k++; end
        chk("wait_idle_bound", 32'(cmd_ready), 32'd1);
    endtask

    int b_start, b_valid, b_to, b_evt;
    task automatic snap();
        b_start = n_start; b_valid = n_valid; b_to = n_to; b_evt = n_evt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        // reset state
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("rst_evt_valid", 32'(evt_valid), 32'd0);
        chk("rst_rsp_code", 32'(rsp_code), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("tx_len", 32'(tx_len), 32'(PL));
        rst = 1'b0;
        tick(2);

        // unsolicited packet while idle, then a bad-CRC and a non-UDP packet
        snap();
        exp_kind = K_EVT; exp_code = 8'h05; exp_arg = 8'hFF;
        send_pkt(8'h05, 8'hFF, 1'b1, 1'b1);
        tick(3);
        chk("unsol_evt", 32'(n_evt - b_evt), 32'd1);
        chk("unsol_code", 32'(rsp_code), 32'h05);
        chk("unsol_arg", 32'(rsp_arg), 32'hFF);
        send_pkt(8'h11, 8'h22, 1'b0, 1'b1);
        send_pkt(8'h33, 8'h44, 1'b1, 1'b0);
        tick(3);
        chk("unsol_evt_after_bad", 32'(n_evt - b_evt), 32'd1);
        chk("unsol_no_start", 32'(n_start - b_start), 32'd0);
        chk("unsol_code_kept", 32'(rsp_code), 32'h05);

        // basic command with a transmitter already busy and a reply dropped during WAIT_TX
        snap();
        tx_hold = 1'b1;
        issue_cmd(8'h01, 8'h01);
        tick(5);
        tx_hold = 1'b0;
        tick(10);
        exp_kind = K_NONE;
        send_pkt(8'h77, 8'h66, 1'b1, 1'b1);
        wait_fall(100);
        tick(20);
        exp_kind = K_VALID; exp_code = 8'h03; exp_arg = 8'h00;
        send_pkt(8'h03, 8'h00, 1'b1, 1'b1);
        tick(3);
        chk("basic_starts", 32'(n_start - b_start), 32'd1);
        chk("basic_valid", 32'(n_valid - b_valid), 32'd1);
        chk("basic_no_evt", 32'(n_evt - b_evt), 32'd0);
        chk("basic_no_timeout", 32'(n_to - b_to), 32'd0);
        chk("basic_pay0", 32'(cap[0]), 32'h01);
        chk("basic_pay1", 32'(cap[1]), 32'h01);
        chk("basic_pay3", 32'(cap[3]), 32'h00);
        chk("basic_rsp_code", 32'(rsp_code), 32'h03);

        // bad-CRC reply: timeout after all attempts; a stray command mid-flight is ignored
        snap();
        exp_kind = K_NONE;
        issue_cmd(8'h3C, 8'hA5);
        wait_fall(150);
        tick(10);
        send_pkt(8'h3C, 8'h01, 1'b0, 1'b1);
        issue_cmd(8'hEE, 8'hEE);
        wait_idle(1000);
        tick(2);
        chk("badcrc_starts", 32'(n_start - b_start), 32'(ATTEMPTS));
        chk("badcrc_timeout", 32'(n_to - b_to), 32'd1);
        chk("badcrc_no_valid", 32'(n_valid - b_valid), 32'd0);
        chk("badcrc_no_evt", 32'(n_evt - b_evt), 32'd0);

        // reply stop lands on the same edge as counter expiry
        snap();
        issue_cmd(8'h5A, 8'hC3);
        wait_fall(150);
        while (cyc < fall_cyc + int'(TO) - 3) tick(1);
        chk("race_align", 32'(cyc), 32'(fall_cyc + int'(TO) - 3));
        exp_kind = K_VALID; exp_code = 8'hC0; exp_arg = 8'h01;
        send_pkt(8'hC0, 8'h01, 1'b1, 1'b1);
        tick(100);
        chk("race_valid", 32'(n_valid - b_valid), 32'd1);
        chk("race_no_timeout", 32'(n_to - b_to), 32'd0);
        chk("race_starts", 32'(n_start - b_start), 32'd1);

        // reset while waiting for a reply, then a late reply arrives
        snap();
        exp_kind = K_NONE;
        issue_cmd(8'h12, 8'h34);
        wait_fall(150);
        tick(5);
        rst = 1'b1;
        tick(1);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_rsp_code", 32'(rsp_code), 32'd0);
        chk("midrst_rsp_arg", 32'(rsp_arg), 32'd0);
        rst = 1'b0;
        tick(60);
        chk("midrst_no_timeout", 32'(n_to - b_to), 32'd0);
        exp_kind = K_EVT; exp_code = 8'h42; exp_arg = 8'h24;
        send_pkt(8'h42, 8'h24, 1'b1, 1'b1);
        tick(3);
        chk("midrst_evt", 32'(n_evt - b_evt), 32'd1);
        chk("midrst_no_valid", 32'(n_valid - b_valid), 32'd0);
        chk("midrst_starts", 32'(n_start - b_start), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/udp_cmd_client.md
UDP_CMD_CLIENT -- requirements
Module: udp_cmd_client

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- TIMEOUT_CYCLES, 1000000, cycles to wait for a reply after transmit ends.
- MAX_RETRY, 3, retransmissions after the first attempt.
- PAYLOAD_LEN, 18, UDP payload length presented on tx_len.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, synchronous, active-high reset.
- cmd_valid, in, 1, command request.
- cmd_ready, out, 1, idle and able to accept a command.
- cmd_code, in, 8, command byte, payload byte 0.
- cmd_arg, in, 8, argument byte, payload byte 1.
- rsp_valid, out, 1, one-cycle pulse: reply captured.
- rsp_code, out, 8, reply byte 0.
- rsp_arg, out, 8, reply byte 1.
- rsp_timeout, out, 1, one-cycle pulse: no reply after all attempts.
- evt_valid, out, 1, one-cycle pulse: unsolicited UDP packet received while idle (code/arg on rsp_code/rsp_arg).
- tx_start, out, 1, one-cycle transmit start strobe to the UDP transmitter.
- tx_len, out, 10, payload length; equals PAYLOAD_LEN.
- tx_data_pos, in, 10, payload byte index requested by the transmitter.
- tx_data, out, 8, payload byte.
- tx_busy, in, 1, transmitter is sending a packet.
- rx_data_avail, in, 1, receive byte strobe.
- rx_data, in, 8, receive byte.
- rx_data_pos, in, 10, receive payload byte index.
- rx_is_udp, in, 1, current receive packet is UDP to the host port.
- rx_stop, in, 1, end-of-packet strobe.
- rx_crc_valid, in, 1, FCS good; qualified by rx_stop.

Function
REQ-003 States: IDLE, SEND, WAIT_TX, WAIT_RSP.
REQ-004 IDLE: cmd_ready=1. If cmd_valid=1, latch cmd_code/cmd_arg, clear the retry counter, and go to SEND.
REQ-005 SEND: wait for tx_busy=0. Then assert tx_start for exactly one cycle and go to WAIT_TX.
REQ-006 WAIT_TX: wait for tx_busy=1, then for tx_busy=0. Then load the timeout counter with TIMEOUT_CYCLES-1 and go to WAIT_RSP.
REQ-007 tx_data is registered, one-cycle latency from tx_data_pos: pos 0 gives latched code, pos 1 gives latched arg, any other pos gives 0x00.
REQ-008 Receive capture:
- When rx_data_avail=1 and rx_is_udp=1, store rx_data at pos 0 into a code shadow and at pos 1 into an arg shadow.
- Other positions are ignored.
REQ-009 A packet is accepted only when rx_stop=1, rx_crc_valid=1 and rx_is_udp=1. With rx_stop=1 and rx_crc_valid=0 the packet is discarded and produces no pulse.
REQ-010 WAIT_RSP, packet accepted:
- Copy the shadows to rsp_code/rsp_arg.
- Pulse rsp_valid the next cycle.
- Go to IDLE.
REQ-011 WAIT_RSP, counter reaches 0 with no accepted packet: go to the retry/timeout handling of REQ-016.
REQ-012 If acceptance and counter expiry occur in the same cycle, acceptance wins.
REQ-013 In IDLE, an accepted packet updates rsp_code/rsp_arg and pulses evt_valid, not rsp_valid. In SEND and WAIT_TX, accepted packets are dropped.
REQ-014 rsp_valid, rsp_timeout and evt_valid are mutually exclusive per cycle.
REQ-015 cmd_valid outside IDLE is ignored; no queueing.

Configuration
REQ-016 Macro UDP_CMD_CLIENT_RETRY_EN:
- Defined: on expiry, if the retry count < MAX_RETRY, increment it and return to SEND with the same latched bytes. Otherwise pulse rsp_timeout and go to IDLE. Total attempts = MAX_RETRY+1.
- Undefined: on the first expiry, pulse rsp_timeout and go to IDLE. The retry counter is not implemented and MAX_RETRY is unused.

Reset
REQ-017 While rst=1 (synchronous):
- State = IDLE.
- cmd_ready=1.
- tx_start, rsp_valid, rsp_timeout, evt_valid = 0.
- rsp_code, rsp_arg, tx_data, shadows and counters = 0.
REQ-018 rst asserted mid-operation abandons the command and produces no pulse. A transmission already started by the external transmitter is not aborted.

Verification
REQ-019 Directed scenarios:
- Basic command: cmd 0x01/0x01; tx_busy high 40 cycles then low; UDP reply 0x03/0x00 with good CRC after 100 cycles -> exactly one tx_start, tx_data 0x01,0x01,0x00..., rsp_valid once with 0x03/0x00.
- Bad CRC: reply with rx_crc_valid=0 -> no rsp_valid. With TIMEOUT_CYCLES=50 and RETRY_EN defined, MAX_RETRY=3 -> 4 tx_start pulses, then rsp_timeout once.
- Retry disabled: RETRY_EN undefined, TIMEOUT_CYCLES=50, no reply -> 1 tx_start; rsp_timeout 50 cycles after tx_busy falls.
- Race: good reply's rx_stop coincides with the counter reaching 0 -> rsp_valid, no rsp_timeout, no retransmit.
- Unsolicited: UDP packet 0x05/0xFF while IDLE -> evt_valid once, rsp_code=0x05, rsp_arg=0xFF, no tx_start.
- Reset: rst in WAIT_RSP -> next cycle IDLE, cmd_ready=1; a later reply gives evt_valid, not rsp_valid.
